wiscsc15_fetch: RTL and testbench

Instruction fetch unit for the WISC-SC15 core. It is the producer end of the instruction word that wiscsc15_ctrl decodes, where Opcode is inst[15:12].
- Owns the PC and issues word-addressed requests to instruction memory, one outstanding request at a time.
- Buffers returned words in a small queue and presents them to decode with a valid/ready handshake.
- Accepts branch/call redirects from the execute stage.

---
 rtl/wiscsc15_fetch_if.sv | 32 +++
 rtl/wiscsc15_fetch.sv | 85 ++++++++
 tb/tb_wiscsc15_fetch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/wiscsc15_fetch_if.sv
// wiscsc15_fetch_if: instruction-memory, decode and redirect signals of the fetch unit
//   imem_*      : word-addressed request/grant bus; one rvalid per grant
//   inst_*      : queue head presented to decode with a valid/ready handshake
//   redirect*   : taken branch/call from execute; halt blocks new requests
//   master      : fetch unit side, slave : memory/decode/execute side
interface wiscsc15_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/wiscsc15_fetch.sv
// wiscsc15_fetch: WISC-SC15 instruction fetch unit with a small instruction queue
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : wiscsc15_fetch_if.master (imem request bus, decode handshake, redirect/halt)
module wiscsc15_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 2
) (
    input logic              clk,
    input logic              rst_n,
    wiscsc15_fetch_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc, req_pc;
    logic [INST_W-1:0] q_inst [QDEPTH];
    logic [ADDR_W-1:0] q_pc [QDEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, occ_next;
    logic              push, pop, granted, can_issue, inst_valid;

    assign granted    = state == REQ && bus.imem_gnt;
    // redirect voids both the arriving word and any pop in the same cycle
    assign push       = state == WAIT && bus.imem_rvalid && !bus.redirect;
    assign pop        = inst_valid && bus.inst_ready && !bus.redirect;
    assign occ_next   = bus.redirect ? '0 : count + CW'(push) - CW'(pop);
    // issuing only when a slot is free guarantees the in-flight word always fits
    assign can_issue  = !bus.halt && occ_next < DEPTH;
    assign inst_valid = count != '0;

    assign bus.imem_req   = state == REQ;
    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = inst_valid;
    assign bus.inst       = inst_valid ? q_inst[rd_ptr] : '0;
    assign bus.inst_pc    = inst_valid ? q_pc[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            if (bus.redirect) fetch_pc <= bus.redirect_pc;
            else if (granted) fetch_pc <= fetch_pc + 1'b1;
            if (granted) req_pc <= fetch_pc;
            case (state)
                IDLE:    state <= can_issue ? REQ : IDLE;
                // an ungranted request is withdrawn by halt; a granted one always completes
                REQ:     state <= bus.imem_gnt ? (bus.redirect ? DROP : WAIT) : (bus.halt ? IDLE : REQ);
                // a response arriving with redirect is already dropped, so nothing is left outstanding
                WAIT,
                DROP:    state <= bus.imem_rvalid ? (can_issue ? REQ : IDLE) : (bus.redirect ? DROP : state);
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count  <= occ_next;
            rd_ptr <= bus.redirect ? '0 : rd_ptr + PW'(pop);
            wr_ptr <= bus.redirect ? '0 : wr_ptr + PW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= bus.imem_rdata;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == DEPTH));
endmodule

// File: tb/tb_wiscsc15_fetch.sv
// tb_wiscsc15_fetch: directed tests for wiscsc15_fetch against a latency-programmable memory
module tb_wiscsc15_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gnt_en = 1'b1;
    int          lat = 1;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cnt1, cnt2;
    logic [15:0] pa1, pa2;

    always #5 clk = ~clk;

    wiscsc15_fetch_if #(.ADDR_W(16), .INST_W(16)) bus ();
    wiscsc15_fetch_if #(.ADDR_W(16), .INST_W(16)) bus2 ();

    wiscsc15_fetch #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'h0000), .QDEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    wiscsc15_fetch #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'hFFFF), .QDEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    assign bus.inst_ready   = inst_ready;
    assign bus.redirect     = redirect;
    assign bus.redirect_pc  = redirect_pc;
    assign bus.halt         = halt;
    assign bus.imem_gnt     = bus.imem_req & gnt_en;
    assign bus2.inst_ready  = inst_ready;
    assign bus2.redirect    = redirect;
    assign bus2.redirect_pc = redirect_pc;
    assign bus2.halt        = halt;
    assign bus2.imem_gnt    = bus2.imem_req & gnt_en;

    // memory contents: opcode 0 (ADD) with the low 12 address bits folded into the operands
    function automatic logic [15:0] word(input logic [15:0] a);
        return {4'h0, a[11:0] ^ 12'hA00};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= 0; pa1 <= '0; bus.imem_rvalid <= 1'b0; bus.imem_rdata <= '0;
        end else begin
            bus.imem_rvalid <= 1'b0;
            if (bus.imem_req && bus.imem_gnt) begin
                if (lat <= 1) begin bus.imem_rvalid <= 1'b1; bus.imem_rdata <= word(bus.imem_addr); end
                else begin cnt1 <= lat - 1; pa1 <= bus.imem_addr; end
            end else if (cnt1 != 0) begin
                cnt1 <= cnt1 - 1;
                if (cnt1 == 1) begin bus.imem_rvalid <= 1'b1; bus.imem_rdata <= word(pa1); end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt2 <= 0; pa2 <= '0; bus2.imem_rvalid <= 1'b0; bus2.imem_rdata <= '0;
        end else begin
            bus2.imem_rvalid <= 1'b0;
            if (bus2.imem_req && bus2.imem_gnt) begin
                if (lat <= 1) begin bus2.imem_rvalid <= 1'b1; bus2.imem_rdata <= word(bus2.imem_addr); end
                else begin cnt2 <= lat - 1; pa2 <= bus2.imem_addr; end
            end else if (cnt2 != 0) begin
                cnt2 <= cnt2 - 1;
                if (cnt2 == 1) begin bus2.imem_rvalid <= 1'b1; bus2.imem_rdata <= word(pa2); end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        inst_ready = 1'b0; gnt_en = 1'b1; lat = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h exp 0000", bus.imem_addr); end
        checks++; if (bus2.imem_addr !== 16'hFFFF) begin errors++; $display("FAIL rst_addr2 got %h exp ffff", bus2.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.inst_valid); end
        checks++; if (bus.inst !== 16'h0000 || bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL rst_head got %h/%h exp 0000/0000", bus.inst, bus.inst_pc); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL first_req got %b/%h exp 1/0000", bus.imem_req, bus.imem_addr); end
        tick();
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_rvalid !== 1'b1) begin errors++; $display("FAIL first_wait got req %b rvalid %b exp 0/1", bus.imem_req, bus.imem_rvalid); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", bus.inst_valid); end
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL first_head got %b/%h exp 1/0000", bus.inst_valid, bus.inst_pc); end
        checks++; if (bus.inst !== 16'h0A00) begin errors++; $display("FAIL first_inst got %h exp 0a00", bus.inst); end
    endtask

    task automatic test_queue_full();
        do_reset();
        repeat (5) tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000 || bus.inst !== 16'h0A00) begin errors++; $display("FAIL full_head got %b/%h/%h exp 1/0000/0a00", bus.inst_valid, bus.inst_pc, bus.inst); end
        tick();
        checks++; if (bus.imem_req !== 1'b0 || bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL full_hold got %b/%h exp 0/0000", bus.imem_req, bus.inst_pc); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (bus.inst_pc !== 16'h0001 || bus.inst !== 16'h0A01) begin errors++; $display("FAIL pop_order got %h/%h exp 0001/0a01", bus.inst_pc, bus.inst); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002) begin errors++; $display("FAIL resume got %b/%h exp 1/0002", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        int i;
        do_reset();
        lat = 3;
        inst_ready = 1'b1;
        for (i = 0; i < 60 && !(bus.imem_req === 1'b1 && bus.imem_addr === 16'h0003); i++) tick();
        checks++; if (i >= 60) begin errors++; $display("FAIL rw_reach_addr3 got timeout exp request"); end
        inst_ready = 1'b0;
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0002) begin errors++; $display("FAIL rw_head got %b/%h exp 1/0002", bus.inst_valid, bus.inst_pc); end
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL rw_flush got valid %b req %b exp 0/0", bus.inst_valid, bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop_wait got %b exp 0", bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rw_refetch got %b/%h/%b exp 1/0040/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        for (i = 0; i < 20 && bus.inst_valid !== 1'b1; i++) tick();
        checks++; if (bus.inst_pc !== 16'h0040 || bus.inst !== 16'h0A40) begin errors++; $display("FAIL rw_first got %h/%h exp 0040/0a40", bus.inst_pc, bus.inst); end
    endtask

    task automatic test_redirect_req();
        int i;
        do_reset();
        gnt_en = 1'b0;
        tick();
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rr_held got %b/%h exp 1/0000", bus.imem_req, bus.imem_addr); end
        redirect = 1'b1; redirect_pc = 16'h0123;
        tick();
        redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0123) begin errors++; $display("FAIL rr_addr got %b/%h exp 1/0123", bus.imem_req, bus.imem_addr); end
        gnt_en = 1'b1;
        for (i = 0; i < 20 && bus.inst_valid !== 1'b1; i++) tick();
        checks++; if (bus.inst_pc !== 16'h0123 || bus.inst !== 16'h0B23) begin errors++; $display("FAIL rr_first got %h/%h exp 0123/0b23", bus.inst_pc, bus.inst); end
    endtask

    task automatic test_wrap();
        int i;
        do_reset();
        inst_ready = 1'b1;
        for (i = 0; i < 20 && bus2.inst_valid !== 1'b1; i++) tick();
        checks++; if (bus2.inst_pc !== 16'hFFFF || bus2.inst !== 16'h05FF) begin errors++; $display("FAIL wrap_first got %h/%h exp ffff/05ff", bus2.inst_pc, bus2.inst); end
        tick();
        for (i = 0; i < 20 && bus2.inst_valid !== 1'b1; i++) tick();
        checks++; if (bus2.inst_pc !== 16'h0000 || bus2.inst !== 16'h0A00) begin errors++; $display("FAIL wrap_second got %h/%h exp 0000/0a00", bus2.inst_pc, bus2.inst); end
    endtask

    task automatic test_halt_and_reset();
        do_reset();
        repeat (3) tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0001) begin errors++; $display("FAIL h_req got %b/%h exp 1/0001", bus.imem_req, bus.imem_addr); end
        gnt_en = 1'b0; halt = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL h_withdraw got %b/%b/%h exp 0/1/0000", bus.imem_req, bus.inst_valid, bus.inst_pc); end
        inst_ready = 1'b1;
        tick();
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL h_drain got %b/%b exp 0/0", bus.inst_valid, bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL h_blocked got %b exp 0", bus.imem_req); end
        halt = 1'b0; gnt_en = 1'b1; inst_ready = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0001) begin errors++; $display("FAIL h_refetch got %b/%h exp 1/0001", bus.imem_req, bus.imem_addr); end
        tick();
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0001) begin errors++; $display("FAIL h_word got %b/%h exp 1/0001", bus.inst_valid, bus.inst_pc); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL async_rst_req got %b/%h exp 0/0000", bus.imem_req, bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== 16'h0000 || bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL async_rst_head got %b/%h/%h exp 0/0000/0000", bus.inst_valid, bus.inst, bus.inst_pc); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_queue_full();
        test_redirect_wait();
        test_redirect_req();
        test_wrap();
        test_halt_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
